// File: rtl/xvec_stream_sender.sv
// xvec_stream_sender: ping-pong frame buffer; host writes wr_*, full frames stream out on m_*_x
module xvec_stream_sender #(
  parameter int WIDTH  = 8,
  parameter int LENX   = 8,
  parameter int LOGLEN = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic signed [WIDTH-1:0] m_data_out_x,
  output logic                    m_valid_x,
  input  logic                    m_ready_x,
  output logic                    m_last_x,
  output logic [15:0]             frames_sent
);
  localparam logic [LOGLEN-1:0] LAST = LOGLEN'(LENX - 1);
  logic [WIDTH-1:0] bank_q [2][LENX];
  logic [WIDTH-1:0] bank_d [2][LENX];
  logic [1:0] full_q, full_d;
  logic w_sel_q, w_sel_d, r_sel_q, r_sel_d;
  logic [LOGLEN-1:0] w_idx_q, w_idx_d, r_idx_q, r_idx_d;
  logic [15:0] frames_sent_q, frames_sent_d;
  logic wr_fire, rd_fire, w_wrap, r_wrap;
  assign wr_ready     = !reset && !full_q[w_sel_q];
  assign m_valid_x    = !reset && full_q[r_sel_q];
  assign m_data_out_x = bank_q[r_sel_q][r_idx_q];
  assign m_last_x     = m_valid_x && r_idx_q == LAST;
  assign frames_sent  = frames_sent_q;
  assign wr_fire      = wr_valid && wr_ready;
  assign rd_fire      = m_valid_x && m_ready_x;
  assign w_wrap       = wr_fire && w_idx_q == LAST;
  assign r_wrap       = rd_fire && r_idx_q == LAST;
  always_comb begin
    bank_d = bank_q;
    if (wr_fire) bank_d[w_sel_q][w_idx_q] = wr_data;
    full_d = full_q;
    if (w_wrap) full_d[w_sel_q] = 1'b1;
    if (r_wrap) full_d[r_sel_q] = 1'b0;
    w_idx_d       = w_wrap ? '0 : wr_fire ? w_idx_q + 1'b1 : w_idx_q;
    r_idx_d       = r_wrap ? '0 : rd_fire ? r_idx_q + 1'b1 : r_idx_q;
    w_sel_d       = w_sel_q ^ w_wrap;
    r_sel_d       = r_sel_q ^ r_wrap;
    frames_sent_d = r_wrap ? frames_sent_q + 16'd1 : frames_sent_q;
    if (reset) begin
      full_d        = '0;
      w_idx_d       = '0;
      r_idx_d       = '0;
      w_sel_d       = 1'b0;
      r_sel_d       = 1'b0;
      frames_sent_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    bank_q        <= bank_d;
    full_q        <= full_d;
    w_idx_q       <= w_idx_d;
    r_idx_q       <= r_idx_d;
    w_sel_q       <= w_sel_d;
    r_sel_q       <= r_sel_d;
    frames_sent_q <= frames_sent_d;
  end
endmodule

// File: tb/tb_xvec_stream_sender.sv
// tb_xvec_stream_sender: directed and random checks of xvec_stream_sender against a sample queue
module tb_xvec_stream_sender;
  localparam int L = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_valid = 1'b0;
  logic m_ready_x = 1'b0;
  logic [7:0] wr_data = '0;
  logic wr_ready, m_valid_x, m_last_x;
  logic [7:0] m_data;
  logic [15:0] frames_sent;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [$];
  int n_wr = 0;
  int n_rd = 0;
  int rd_pos = 0;
  logic [15:0] exp_frames = '0;
  logic stall = 1'b0;
  logic [7:0] stall_data = '0;
  logic stall_last = 1'b0;
  int base_w, base_r;
  xvec_stream_sender #(.WIDTH(8), .LENX(L), .LOGLEN(3)) dut (
    .clk(clk),
    .reset(reset),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .m_data_out_x(m_data),
    .m_valid_x(m_valid_x),
    .m_ready_x(m_ready_x),
    .m_last_x(m_last_x),
    .frames_sent(frames_sent)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic sb_step();
    logic [7:0] e;
    if (reset) begin
      exp_q.delete();
      rd_pos = 0;
      exp_frames = '0;
      stall = 1'b0;
    end else begin
      chk("frames_sent", frames_sent, exp_frames);
      if (stall) begin
        chk("hold_valid", m_valid_x, 1);
        chk("hold_data", m_data, stall_data);
        chk("hold_last", m_last_x, stall_last);
      end
      if (wr_valid && wr_ready) begin
        exp_q.push_back(wr_data);
        n_wr++;
      end
      if (m_valid_x && m_ready_x) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = 'x;
        chk("sb_data", m_data, e);
        chk("sb_last", m_last_x, rd_pos == L - 1);
        n_rd++;
        rd_pos = (rd_pos == L - 1) ? 0 : rd_pos + 1;
        if (rd_pos == 0) exp_frames++;
      end
      stall = m_valid_x && !m_ready_x;
      stall_data = m_data;
      stall_last = m_last_x;
    end
  endtask
  task automatic tick();
    @(negedge clk);
    sb_step();
    @(posedge clk);
    #1;
  endtask
  task automatic write_n(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_data = 8'(base + i);
      wr_valid = 1'b1;
      tick();
    end
    wr_valid = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_valid", m_valid_x, 0);
    chk("rst_ready", wr_ready, 0);
    chk("rst_last", m_last_x, 0);
    chk("rst_frames", frames_sent, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", wr_ready, 1);
    chk("valid_after_rst", m_valid_x, 0);
    write_n(1, 8);
    chk("f1_valid", m_valid_x, 1);
    chk("f1_data", m_data, 1);
    chk("f1_last", m_last_x, 0);
    chk("f1_wr_ready", wr_ready, 1);
    repeat (3) tick();
    chk("f1_held_data", m_data, 1);
    chk("f1_held_valid", m_valid_x, 1);
    write_n(9, 8);
    chk("both_full_ready", wr_ready, 0);
    wr_data = 8'd99;
    wr_valid = 1'b1;
    tick();
    tick();
    chk("reject_99_ready", wr_ready, 0);
    wr_valid = 1'b0;
    chk("reject_99_queue", exp_q.size(), 16);
    m_ready_x = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_valid", m_valid_x, 1);
      chk("drain_data", m_data, i);
      chk("drain_last", m_last_x, i == 8 || i == 16);
      chk("drain_wr_ready", wr_ready, i > 8);
      tick();
    end
    m_ready_x = 1'b0;
    chk("drain_done_valid", m_valid_x, 0);
    chk("drain_frames", frames_sent, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    base_w = n_wr;
    base_r = n_rd;
    for (int c = 0; c < 60000 && n_rd - base_r < 8000; c++) begin
      wr_valid = (n_wr - base_w < 8000) && ($urandom_range(0, 1) == 1);
      wr_data = 8'($urandom);
      m_ready_x = ($urandom_range(0, 1) == 1);
      tick();
    end
    wr_valid = 1'b0;
    m_ready_x = 1'b0;
    chk("rand_count", n_rd - base_r, 8000);
    chk("rand_frames", frames_sent, 1000);
    chk("rand_queue_empty", exp_q.size(), 0);
    write_n(10, 8);
    m_ready_x = 1'b1;
    repeat (5) tick();
    chk("mid_data", m_data, 15);
    chk("mid_frames", frames_sent, 1000);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", m_valid_x, 0);
    chk("mid_rst_frames", frames_sent, 0);
    chk("mid_rst_ready", wr_ready, 0);
    reset = 1'b0;
    m_ready_x = 1'b0;
    tick();
    chk("post_rst_valid", m_valid_x, 0);
    chk("post_rst_ready", wr_ready, 1);
    write_n(40, 8);
    chk("fresh_valid", m_valid_x, 1);
    chk("fresh_data", m_data, 40);
    m_ready_x = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("fresh_drain", m_data, 40 + i);
      tick();
    end
    m_ready_x = 1'b0;
    chk("fresh_frames", frames_sent, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    write_n(50, 8);
    write_n(60, 7);
    m_ready_x = 1'b1;
    repeat (7) tick();
    chk("same_edge_pre_data", m_data, 57);
    chk("same_edge_pre_last", m_last_x, 1);
    wr_data = 8'd67;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("same_edge_valid", m_valid_x, 1);
    chk("same_edge_data", m_data, 60);
    chk("same_edge_last", m_last_x, 0);
    chk("same_edge_wr_ready", wr_ready, 1);
    chk("same_edge_frames", frames_sent, 1);
    for (int i = 0; i < 8; i++) begin
      chk("same_edge_drain", m_data, 60 + i);
      tick();
    end
    m_ready_x = 1'b0;
    chk("final_frames", frames_sent, 2);
    chk("final_valid", m_valid_x, 0);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xvec_stream_sender.md
Name: xvec_stream_sender

Overview:
- Transmit side of the x-vector valid/ready stream consumed by the convolution cores (the conv_* s_data_in_x / s_valid_x / s_ready_x input).
- A host writes samples one at a time into a two-bank (ping-pong) frame buffer of LENX samples per bank.
- Each full frame is streamed out in write order under m_ready_x backpressure, so one bank fills while the other drains.

Parameters:
- WIDTH, 8, sample width in bits.
- LENX, 8, samples per frame; must match the receiving conv core's LENX.
- LOGLEN, 3, index width; ceil(log2(LENX)).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- wr_data  in  WIDTH  host sample.
- wr_valid  in  1  host sample valid.
- wr_ready  out  1  buffer can accept wr_data this cycle.
- m_data_out_x  out  WIDTH  stream sample, signed, to the conv core s_data_in_x.
- m_valid_x  out  1  stream valid, to the conv core s_valid_x.
- m_ready_x  in  1  stream ready, from the conv core s_ready_x.
- m_last_x  out  1  high with the final sample of each frame.
- frames_sent  out  16  count of completed frames; wraps modulo 2^16.

Behaviour:
- State:
  - bank[2][LENX] sample registers.
  - full[1:0] flags.
  - w_sel and w_idx (write bank and index).
  - r_sel and r_idx (read bank and index).
  - frames_sent counter.
- Reset (synchronous; dominates every other event in the same cycle):
  - full=00, w_sel=r_sel=0, w_idx=r_idx=0, frames_sent=0.
  - m_valid_x=0, m_last_x=0, wr_ready=0 while reset is high.
  - Bank contents are don't-care.
- Write side:
  - wr_ready = !reset && !full[w_sel].
  - Write accepted when wr_valid && wr_ready: bank[w_sel][w_idx] <= wr_data, w_idx++.
  - If the accepted write has w_idx==LENX-1: full[w_sel] <= 1, w_idx <= 0, w_sel toggles.
- Read side:
  - m_valid_x = full[r_sel].
  - m_data_out_x = bank[r_sel][r_idx].
  - m_last_x = m_valid_x && (r_idx==LENX-1).
  - Transfer occurs when m_valid_x && m_ready_x: r_idx++.
  - If the transfer is the last sample: full[r_sel] <= 0, r_idx <= 0, r_sel toggles, frames_sent++.
- Stream rules:
  - While m_valid_x && !m_ready_x, m_data_out_x and m_last_x hold stable.
  - m_valid_x never deasserts without a transfer, except on reset.
  - m_valid_x depends only on registered state. There is no combinational path from m_ready_x to m_valid_x or to m_data_out_x.
- Latency:
  - Last write of a frame at edge t, read side idle → m_valid_x=1 in the cycle after edge t; first sample is visible then.
  - Back-to-back frames stream with zero bubble cycles when both banks are full.
- Boundary conditions:
  - Both banks full: wr_ready=0; writes are ignored and w_idx is unchanged.
  - Bank freed by a last-sample transfer at edge t: wr_ready for that bank rises in the cycle after t.
  - The same bank is never written and drained at once: the write bank is never the full bank.
  - Filling bank A and finishing the drain of bank B on the same edge: both flag updates take effect. The next cycle shows m_valid_x=1 with bank A's first sample, and wr_ready=1 into bank B.
  - Frame order is strictly preserved, because w_sel and r_sel toggle in lockstep order.
  - A partial frame (w_idx>0, bank not full) is never emitted.
  - Reset mid-frame discards all buffered and partial frames; the next accepted sample is index 0 of bank 0.
- Arithmetic:
  - Indices compare against LENX-1 exactly; LENX need not be a power of 2.
  - frames_sent wraps from 65535 to 0.

Test Plan:
- Reset, write 1..8 with m_ready_x=0 → m_valid_x=1 the cycle after the 8th write, m_data_out_x=1 held, m_last_x=0, wr_ready=1.
- Write 1..16 with m_ready_x=0 → wr_ready=0 after the 16th write; a 17th write (value 99) is not accepted; later output contains no 99.
- Continuing from the previous case, hold m_ready_x=1 → outputs 1..16 on 16 consecutive cycles with no bubble. m_last_x is high on values 8 and 16. wr_ready returns to 1 the cycle after the 8th transfer. frames_sent=2.
- Random wr_valid / m_ready_x at 50%, 1000 frames of random data → exact sequence match against a host-side queue; frames_sent=1000.
- Reset asserted after 5 of 8 samples have been sent → m_valid_x=0 and frames_sent=0 the next cycle. A fresh frame 40..47 is emitted starting at 40.
- Drive the 8th write into bank 1 on the same edge as the last transfer of bank 0 → next cycle m_valid_x=1 with bank 1 sample 0, wr_ready=1, frames_sent incremented by 1.
